sbp_lookup_collector: RTL
=========================

Name: sbp_lookup_collector

Overview:
Request front-end and result back-end wrapped around the lookup pipeline. It accepts tagged IPv4 lookup requests over a valid/ready handshake and drives the pipeline's per-cycle address input, injecting a zero address as a bubble on idle cycles. A valid/tag/address shadow shift register tracks the fixed pipeline latency and re-associates each result with its request. Results go into an output FIFO. A credit scheme guarantees that FIFO can never overflow, because the pipeline itself cannot stall.

Parameters:
LOOKUP_LATENCY, 64, cycles from lookup_ip_addr_o to the matching lookup_result_i; must be at least 1.
TAG_BITS, 8, width of the opaque request tag.
STAGE_ID_BITS, 6, stage-id field width of the pipeline result.
LOCATION_BITS, 11, location field width of the pipeline result.
FIFO_DEPTH, 128, output FIFO entries; power of two; must be at least 2.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
in_valid_i  in  1  request valid.
in_ready_o  out  1  request ready.
in_tag_i  in  TAG_BITS  request tag.
ip_addr_i  in  32  address to look up.
lookup_ip_addr_o  out  32  address to the pipeline, registered.
lookup_result_i  in  LOCATION_BITS+STAGE_ID_BITS  result from the pipeline.
out_valid_o  out  1  response valid; FIFO head, first-word-fall-through.
out_ready_i  in  1  response ready.
out_tag_o  out  TAG_BITS  tag of the response.
out_ip_addr_o  out  32  address that was looked up.
out_result_o  out  LOCATION_BITS+STAGE_ID_BITS  raw pipeline result.
out_hit_o  out  1  1 when out_result_o is nonzero.
inflight_o  out  $clog2(FIFO_DEPTH)+1  requests accepted but not yet written to the FIFO.

Behaviour:
- Reset values: all shadow valid bits 0; inflight and FIFO counts 0; FIFO pointers 0; lookup_ip_addr_o 0; out_valid_o 0; in_ready_o 0 while rst is high.
- Accept: in_valid_i & in_ready_o at a rising edge.
- in_ready_o = !rst & (fifo_count + inflight < FIFO_DEPTH). Combinational from registers only; it never depends on in_valid_i.
- Address drive, at every edge:
  - lookup_ip_addr_o <= accept ? ip_addr_i : 32'h0.
  - Shadow stage 0 <= {accept, in_tag_i, ip_addr_i}.
- Shadow register: LOOKUP_LATENCY+1 entries, shifting every cycle unconditionally.
  - The last entry is aligned with lookup_result_i.
  - When the last entry's valid is 1, at that edge write {tag, ip, lookup_result_i} into the FIFO.
  - Results whose shadow valid is 0 (bubbles) are discarded.
- Latency:
  - Request accepted at edge E appears on the outputs (out_valid_o=1) after edge E+LOOKUP_LATENCY+1.
  - Throughput is one request per cycle while credits are available.
- Counters:
  - inflight: +1 on accept, -1 on FIFO write; both at once leaves it unchanged.
  - fifo_count: +1 on write, -1 on pop (out_valid_o & out_ready_i); both at once leaves it unchanged.
  - Pop and write in the same cycle on a full FIFO is impossible by credit construction.
- Write while empty: data becomes visible on the next cycle; there is no same-cycle bypass.
- Ordering: responses leave strictly in acceptance order.
- Output stability: while out_valid_o=1 & out_ready_i=0, all out_* fields are held stable.
- Overflow check: an assertion fires if a FIFO write occurs with fifo_count==FIFO_DEPTH. It must be unreachable.
- Reset mid-operation:
  - All in-flight and queued requests are dropped.
  - Pipeline results that arrive after reset release are ignored, because the shadow valids were cleared.
  - The FIFO storage RAM itself is not required to clear.
- Pointer wrap-around uses natural binary overflow of $clog2(FIFO_DEPTH)-bit pointers. Full/empty are derived from fifo_count.

Test Plan (LOOKUP_LATENCY=4, FIFO_DEPTH=8, pipeline model = 4-cycle delay line returning {ip[10:0], 6'd3} for nonzero ip, else 0):
- Single request tag=0x11, ip=0x0A000001, out_ready_i=1, accepted at edge E -> out_valid_o high after E+5 with tag 0x11, result {11'h001,6'd3}, out_hit_o=1; one pulse only.
- 20 back-to-back requests with tags 0..19, out_ready_i=1 -> in_ready_o stays 1, responses on consecutive cycles in tag order 0..19, inflight_o peaks at 5.
- out_ready_i=0, 12 requests offered -> exactly 8 accepted, in_ready_o drops once fifo_count+inflight=8; out_ready_i then raised -> the 8 responses drain in order, then the remaining 4 are accepted; no overflow assertion.
- ip_addr_i=0 request -> out_hit_o=0 and out_result_o=0. Idle bubble cycles interleaved with requests -> no spurious responses.
- Random in_valid_i/out_ready_i over 10k cycles with a scoreboard -> every accepted tag is returned exactly once, in order, and the FIFO pointers wrap cleanly.
- rst asserted for 1 cycle with 3 requests in flight and 2 queued -> out_valid_o=0 and inflight_o=0 immediately; the stale pipeline results are ignored; the next request completes normally after 5 cycles.

Source files
------------

// File: rtl/sbp_lookup_collector.sv
// Request front-end and result back-end around the fixed-latency lookup
// pipeline: shadow tracking of in-flight requests and credit-guarded FIFO.
module sbp_lookup_collector #(
    parameter int LOOKUP_LATENCY = 64,
    parameter int TAG_BITS       = 8,
    parameter int STAGE_ID_BITS  = 6,
    parameter int LOCATION_BITS  = 11,
    parameter int FIFO_DEPTH     = 128
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [TAG_BITS-1:0]                    in_tag_i,
    input  logic [31:0]                            ip_addr_i,
    output logic [31:0]                            lookup_ip_addr_o,
    input  logic [LOCATION_BITS+STAGE_ID_BITS-1:0] lookup_result_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [TAG_BITS-1:0]                    out_tag_o,
    output logic [31:0]                            out_ip_addr_o,
    output logic [LOCATION_BITS+STAGE_ID_BITS-1:0] out_result_o,
    output logic                                   out_hit_o,
    output logic [$clog2(FIFO_DEPTH):0]            inflight_o
);

    localparam int RW = LOCATION_BITS + STAGE_ID_BITS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_BITS + 32 + RW;

    logic            accept;
    logic            fifo_write;
    logic            fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight;
    logic [CW:0]     credit_used;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [EW-1:0]   head;

    logic [LOOKUP_LATENCY:0] sh_valid;
    logic [TAG_BITS-1:0]     sh_tag [LOOKUP_LATENCY+1];
    logic [31:0]             sh_ip  [LOOKUP_LATENCY+1];
    logic [EW-1:0]           mem    [FIFO_DEPTH];

    // Credits cover both queued and in-flight entries, so the FIFO can
    // always absorb every result the non-stallable pipeline returns.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready_o  = !rst && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign accept      = in_valid_i & in_ready_o;
    assign fifo_write  = sh_valid[LOOKUP_LATENCY];
    assign fifo_pop    = out_valid_o & out_ready_i;

    assign out_valid_o = (fifo_count != '0);
    assign head        = mem[rd_ptr];
    assign out_tag_o     = head[EW-1 -: TAG_BITS];
    assign out_ip_addr_o = head[RW +: 32];
    assign out_result_o  = head[RW-1:0];
    assign out_hit_o     = |out_result_o;
    assign inflight_o    = inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_ip_addr_o <= '0;
            sh_valid         <= '0;
            inflight         <= '0;
            fifo_count       <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
        end else begin
            lookup_ip_addr_o <= accept ? ip_addr_i : 32'h0;
            sh_valid         <= {sh_valid[LOOKUP_LATENCY-1:0], accept};
            inflight         <= inflight + CW'(accept) - CW'(fifo_write);
            fifo_count       <= fifo_count + CW'(fifo_write) - CW'(fifo_pop);
            wr_ptr           <= wr_ptr + PW'(fifo_write);
            rd_ptr           <= rd_ptr + PW'(fifo_pop);
        end
    end

    // Shadow payload and FIFO storage need no reset; valid bits gate them.
    always_ff @(posedge clk) begin
        sh_tag[0] <= in_tag_i;
        sh_ip[0]  <= ip_addr_i;
        for (int i = 1; i <= LOOKUP_LATENCY; i++) begin
            sh_tag[i] <= sh_tag[i-1];
            sh_ip[i]  <= sh_ip[i-1];
        end
        if (fifo_write)
            mem[wr_ptr] <= {sh_tag[LOOKUP_LATENCY],
                            sh_ip[LOOKUP_LATENCY],
                            lookup_result_i};
    end

    always @(posedge clk) begin
        if (!rst && fifo_write)
            assert (fifo_count != CW'(FIFO_DEPTH));
    end

endmodule
